// File: rtl/mc_control_fsm.sv
// Sequencing controller for the multicycle RV32I core: a Moore FSM that drives
// datapath enables, mux selects and the ALU function, and counts retirements.
module mc_control_fsm #(
  parameter bit TRAP_EN  = 1'b1,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          imm_src,
  output logic [2:0]          alu_control,
  output logic                reg_write,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [RETIRE_W-1:0] RETIRE_ONE = 1;

  // State-only controls, registered from the next state so they are glitch-free
  // in the cycle the state is entered.
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic       pc_jal;
    logic       fetch;
    logic       beq;
    logic       trap;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.result_src = 2'b10;
        c.alu_src_b  = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BEQ: begin
        c.beq       = 1'b1;
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
      end
      S_JAL: begin
        c.pc_jal    = 1'b1;
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
      end
      S_TRAP:     c.trap = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_t              state_q, state_d;
  ctrl_t               ctrl_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                retire_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = TRAP_EN ? S_TRAP : S_FETCH;
        endcase
      end
      // lw and sw differ only in op[5]
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retire_d = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BEQ: retire_d = 1'b1;
      S_MEMWRITE:              retire_d = mem_ready;
      default:                 retire_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= decode_state(S_FETCH);
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_state(state_d);
      if (retire_d) retired_q <= retired_q + RETIRE_ONE;
    end
  end

  always_comb begin
    alu_control = 3'b000;
    case (ctrl_q.alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b100:  alu_control = 3'b100;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          3'b001:  alu_control = 3'b110;
          3'b101:  alu_control = 3'b111;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Input-dependent enables are combined here; reset masks them immediately.
  assign pc_write   = ~reset & (ctrl_q.pc_jal | (ctrl_q.fetch & mem_ready) | (ctrl_q.beq & zero));
  assign ir_write   = ~reset & ctrl_q.fetch & mem_ready;
  assign mem_write  = ~reset & ctrl_q.mem_write;
  assign reg_write  = ~reset & ctrl_q.reg_write;
  assign adr_src    = ctrl_q.adr_src;
  assign result_src = ctrl_q.result_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign trap       = ctrl_q.trap;
  assign retired    = retired_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: each instruction is expanded into its phase list and
// walked cycle by cycle with random stalls; two instances cover both TRAP_EN values.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0, reset1;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, zero, mem_ready;

  logic pw1, as1, mw1, iw1, rw1, tr1;
  logic [1:0] rs1, sa1, sb1, is1;
  logic [2:0] ac1;
  logic [31:0] ret1;
  logic [3:0] sd1;

  logic pw0, as0, mw0, iw0, rw0, tr0;
  logic [1:0] rs0, sa0, sb0, is0;
  logic [2:0] ac0;
  logic [2:0] ret0;
  logic [3:0] sd0;

  mc_control_fsm #(.TRAP_EN(1'b1), .RETIRE_W(32)) dut1 (
    .clk(clk), .reset(reset1), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pw1), .adr_src(as1),
    .mem_write(mw1), .ir_write(iw1), .result_src(rs1), .alu_src_a(sa1),
    .alu_src_b(sb1), .imm_src(is1), .alu_control(ac1), .reg_write(rw1),
    .trap(tr1), .retired(ret1), .state_dbg(sd1)
  );

  mc_control_fsm #(.TRAP_EN(1'b0), .RETIRE_W(3)) dut0 (
    .clk(clk), .reset(reset0), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pw0), .adr_src(as0),
    .mem_write(mw0), .ir_write(iw0), .result_src(rs0), .alu_src_a(sa0),
    .alu_src_b(sb0), .imm_src(is0), .alu_control(ac0), .reg_write(rw0),
    .trap(tr0), .retired(ret0), .state_dbg(sd0)
  );

  logic        sel;
  logic [12:0] ctrl_o;
  logic [2:0]  alu_o;
  logic [1:0]  imm_o;
  logic [31:0] ret_o;
  logic [3:0]  st_o;

  always_comb begin
    if (sel) begin
      ctrl_o = {pw1, as1, mw1, iw1, rs1, sa1, sb1, rw1, tr1};
      alu_o = ac1; imm_o = is1; ret_o = ret1; st_o = sd1;
    end else begin
      ctrl_o = {pw0, as0, mw0, iw0, rs0, sa0, sb0, rw0, tr0};
      alu_o = ac0; imm_o = is0; ret_o = {29'd0, ret0}; st_o = sd0;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] ret_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, reg_write, trap}
  function automatic logic [12:0] exp_ctrl(input int st, input logic mr, input logic z);
    logic pw, as, mw, iw, rw, t;
    logic [1:0] rs, a, b;
    pw = 0; as = 0; mw = 0; iw = 0; rw = 0; t = 0; rs = 0; a = 0; b = 0;
    case (st)
      0:  begin pw = mr; iw = mr; rs = 2'b10; b = 2'b10; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  as = 1;
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin as = 1; mw = 1; end
      6:  a = 2'b10;
      7:  begin a = 2'b10; b = 2'b01; end
      8:  rw = 1;
      9:  begin a = 2'b10; pw = z; end
      10: begin a = 2'b01; b = 2'b10; pw = 1; end
      15: t = 1;
      default: ;
    endcase
    return {pw, as, mw, iw, rs, a, b, rw, t};
  endfunction

  function automatic logic [2:0] exp_alu(input int st, input logic [2:0] f3, input logic f7, input logic [6:0] o);
    if (st == 9) return 3'b001;
    if (st == 6 || st == 7) begin
      case (f3)
        3'b000:  return (f7 && o[5]) ? 3'b001 : 3'b000;
        3'b010:  return 3'b101;
        3'b100:  return 3'b100;
        3'b110:  return 3'b011;
        3'b111:  return 3'b010;
        3'b001:  return 3'b110;
        3'b101:  return 3'b111;
        default: return 3'b000;
      endcase
    end
    return 3'b000;
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // fs/ms: low mem_ready cycles in FETCH and in the memory phase (negative = random)
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fs_in, input int ms_in);
    int q[$];
    int idx, stall, cyc, base, fs, ms;
    bit has_mem, trapped, waitp;
    logic mr;
    logic [31:0] mask;
    fs = (fs_in < 0) ? int'($urandom_range(0, 3)) : fs_in;
    ms = (ms_in < 0) ? int'($urandom_range(0, 3)) : ms_in;
    mask = sel ? 32'hFFFF_FFFF : 32'h7;
    has_mem = 0;
    case (o)
      7'b0000011: begin q = '{0, 1, 2, 3, 4}; base = 5; has_mem = 1; end
      7'b0100011: begin q = '{0, 1, 2, 5};    base = 4; has_mem = 1; end
      7'b0110011: begin q = '{0, 1, 6, 8};    base = 4; end
      7'b0010011: begin q = '{0, 1, 7, 8};    base = 4; end
      7'b1100011: begin q = '{0, 1, 9};       base = 3; end
      7'b1101111: begin q = '{0, 1, 10, 8};   base = 4; end
      default: begin
        if (sel) q = '{0, 1, 15}; else q = '{0, 1};
        base = 2;
      end
    endcase
    idx = 0; stall = fs; cyc = 0; trapped = 0;
    while (1) begin
      @(negedge clk);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      waitp = (q[idx] == 0 || q[idx] == 3 || q[idx] == 5);
      if (waitp) mr = (stall == 0);
      else mr = ($urandom_range(0, 1) != 0);
      mem_ready = mr;
      #1;
      chk("state", 32'(st_o), q[idx]);
      chk("ctrl", 32'(ctrl_o), 32'(exp_ctrl(q[idx], mr, z)));
      chk("alu_control", 32'(alu_o), 32'(exp_alu(q[idx], f3, f7, o)));
      chk("imm_src", 32'(imm_o), 32'(exp_imm(o)));
      chk("retired", ret_o, ret_model & mask);
      if (q[idx] == 15) begin
        trapped = 1;
        break;
      end
      @(posedge clk);
      cyc++;
      if (waitp && !mr) stall--;
      else begin
        if (q[idx] inside {4, 5, 8, 9}) ret_model = ret_model + 1;
        idx++;
        if (idx == q.size()) break;
        stall = (q[idx] == 0) ? fs : ms;
      end
    end
    if (!trapped) chk("cycles", cyc, base + fs + (has_mem ? ms : 0));
    $display("instr op=%b f3=%b f7=%b zero=%b fs=%0d ms=%0d cycles=%0d trapped=%0d retired_model=%0d",
             o, f3, f7, z, fs, ms, cyc, trapped, ret_model & mask);
  endtask

  logic [6:0] legal_ops [6];
  logic [6:0] mix_ops [8];

  initial begin
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    mix_ops   = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                  7'b1110011, 7'b0000000};
    sel = 1; reset1 = 1; reset0 = 1;
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 0; zero = 0; mem_ready = 1;
    ret_model = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(st_o), 0);
    chk("reset_ctrl", 32'(ctrl_o), 32'(exp_ctrl(0, 1'b0, 1'b0)));
    chk("reset_retired", ret_o, 0);
    mem_ready = 0;
    @(negedge clk); reset1 = 0;

    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1, 0);
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);

    for (int i = 0; i < 40; i++)
      run_instr(legal_ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                ($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0), -1, -1);

    // Reset in the middle of a stalled store
    @(negedge clk); op = 7'b0100011; mem_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); mem_ready = 0;
    #1;
    chk("mid_state", 32'(st_o), 5);
    chk("mid_mem_write", 32'(mw1), 1);
    #2 reset1 = 1;
    #1;
    chk("mid_reset_state", 32'(st_o), 0);
    chk("mid_reset_ctrl", 32'(ctrl_o), 32'(exp_ctrl(0, 1'b0, 1'b0)));
    chk("mid_reset_retired", ret_o, 0);
    ret_model = 0;
    @(negedge clk); reset1 = 0;

    run_instr(7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0);

    // Unsupported opcode traps and holds
    run_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); mem_ready = ($urandom_range(0, 1) != 0);
      #1;
      chk("trap_state", 32'(st_o), 15);
      chk("trap_ctrl", 32'(ctrl_o), 32'(exp_ctrl(15, mem_ready, zero)));
      chk("trap_retired", ret_o, ret_model);
    end
    #2 reset1 = 1;
    #1;
    chk("trap_reset_state", 32'(st_o), 0);
    chk("trap_reset_ctrl", 32'(ctrl_o), 32'(exp_ctrl(0, 1'b0, 1'b0)));
    chk("trap_reset_retired", ret_o, 0);
    ret_model = 0;
    mem_ready = 0;
    @(negedge clk); reset1 = 0;
    run_instr(7'b0110011, 3'b100, 1'b0, 1'b0, 0, 0);

    // TRAP_EN=0 instance with a 3-bit counter
    @(negedge clk); reset1 = 1; sel = 0; mem_ready = 0;
    #1;
    chk("nt_reset_state", 32'(st_o), 0);
    chk("nt_reset_retired", ret_o, 0);
    ret_model = 0;
    @(negedge clk); reset0 = 0;
    run_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++)
      run_instr(mix_ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
                ($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0), -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Moore-style sequencing controller for the multicycle RV32I core. It is the successor to the single-cycle decoder and shares one ALU and one unified instruction/data memory across multiple cycles per instruction. It drives all datapath enables and mux selects from an internal state register. It stalls on a memory ready handshake and traps on unsupported opcodes. It also counts retired instructions for the HEX display.

Parameters:
TRAP_EN, 1, 1 = unknown opcode enters TRAP and halts; 0 = unknown opcode is treated as a NOP (DECODE -> FETCH, not counted as retired)
RETIRE_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
op  in  7  opcode, Instr[6:0] from the instruction register
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory or I/O access completes this cycle
pc_write  out  1  PC register enable
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register and OldPC enable
result_src  out  2  00 = ALUOut, 01 = Data register, 10 = ALUResult
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = A register
alu_src_b  out  2  00 = B register, 01 = ImmExt, 10 = constant 4
imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
reg_write  out  1  register file write enable
trap  out  1  high while in TRAP
retired  out  RETIRE_W  count of completed instructions
state_dbg  out  4  current state encoding

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=15.
- Reset:
  - Asynchronous. State = FETCH, retired = 0, trap = 0.
  - While reset is high, pc_write, ir_write, reg_write and mem_write are forced to 0.
- imm_src is decoded combinationally from op in every state:
  - lw / I-ALU -> 00, sw -> 01, beq -> 10, jal -> 11, other -> 00.
- alu_control:
  - ALUOp=00 -> add; ALUOp=01 -> sub.
  - ALUOp=10 decodes funct3: 000 = add, or sub when funct7b5 & op[5]; 010 = slt; 100 = xor; 110 = or; 111 = and; 001 = sll; 101 = srl.
  - Any other funct3 -> add.
- Per-state outputs and transitions (any signal not listed is 0; selects not listed are 00):
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, ALUOp=00, result_src=10.
    - ir_write = pc_write = mem_ready.
    - Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
  - DECODE: alu_src_a=01, alu_src_b=01, ALUOp=00 (branch/jump target into ALUOut).
    - 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
    - Any other opcode -> TRAP if TRAP_EN, else FETCH.
  - MEMADR: alu_src_a=10, alu_src_b=01, ALUOp=00. lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Hold until mem_ready, then MEMWB.
  - MEMWB: result_src=01, reg_write=1. Retire; go to FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1.
    - mem_write stays high every cycle until mem_ready; write data and address are stable for that whole time.
    - On mem_ready: retire; go to FETCH.
  - EXECR: alu_src_a=10, alu_src_b=00, ALUOp=10. Go to ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, ALUOp=10. Go to ALUWB.
  - ALUWB: result_src=00, reg_write=1. Retire; go to FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, ALUOp=01, result_src=00, pc_write=zero. Retire; go to FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, ALUOp=00, result_src=00, pc_write=1. Go to ALUWB (writes PC+4 to rd).
  - TRAP: all enables 0, trap=1. Remain in TRAP until reset.
- Retire:
  - retired increments by 1 on the clock edge that leaves MEMWB, ALUWB, BEQ, or MEMWRITE (with mem_ready).
  - The counter wraps modulo 2^RETIRE_W.
- Cycle counts with mem_ready tied to 1: lw = 5, sw = 4, R-type = 4, I-ALU = 4, beq = 3, jal = 4.
- Every extra cycle with mem_ready low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset asserted mid-instruction: state returns to FETCH immediately (asynchronously). No partial write completes after reset rises.

Test Plan:
- Reset then release with mem_ready=1 and op=0110011, funct3=110 -> states 0,1,6,8,0. alu_control=011 in EXECR. reg_write=1 only in ALUWB. retired=1.
- op=0000011 with mem_ready held low for 3 cycles in MEMREAD -> state 3 held for 4 cycles total, then 4,0. reg_write pulses once with result_src=01. Total instruction = 8 cycles.
- op=0100011 with mem_ready low for 2 cycles in MEMWRITE -> mem_write=1 and adr_src=1 for 3 consecutive cycles. retired increments exactly once.
- op=1100011 twice, zero=1 then zero=0 -> pc_write=1 in the first BEQ cycle, 0 in the second. alu_control=001 both times. retired += 2.
- op=1101111 -> states 0,1,10,8,0. pc_write=1 in JAL. alu_src_b=10 in JAL. reg_write in ALUWB.
- op=1110011 with TRAP_EN=1 -> state 15, trap=1, no enables for 20 cycles. Asserting reset returns to state 0 with retired=0. Same op with TRAP_EN=0 -> back to FETCH, retired unchanged.
